// File: rtl/intermout_sig_compactor.sv
// intermout_sig_compactor
// Response compactor: folds accepted samples into a MISR signature, counts
// them, and after NSAMP samples compares the signature with exp_sig.
// Optional feature macro: SIGCMP_TIMEOUT_EN adds a stall counter that aborts
// a run after TIMEOUT consecutive cycles in RUN without an accept.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready is high only in RUN and never depends
// on in_valid in the same cycle.
module intermout_sig_compactor #(
    parameter int                 WIDTH   = 8,
    parameter int                 NSAMP   = 16,
    parameter logic [WIDTH-1:0]   POLY    = 'h1D,
    parameter logic [WIDTH-1:0]   SEED    = '0,
    parameter int                 TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [WIDTH-1:0]           exp_sig,
    output logic [WIDTH-1:0]           sig,
    output logic [$clog2(NSAMP+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [1:0]                 state_dbg
);

    localparam int CW = $clog2(NSAMP+1);
    localparam logic [CW-1:0] LAST = CW'(NSAMP-1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] sig_next;

    assign state_dbg = state;
    assign accept    = in_valid & in_ready;

    // Next MISR value: shift left, fold in taps when the MSB falls out, xor the sample
    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ in_data;
    end

`ifdef SIGCMP_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT+1);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT);

    logic [SW-1:0] stall;
    logic          timeout_r;

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Run control FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sig      <= SEED;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
`ifdef SIGCMP_TIMEOUT_EN
            stall     <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        sig      <= SEED;
                        count    <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef SIGCMP_TIMEOUT_EN
                        stall     <= '0;
                        timeout_r <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef SIGCMP_TIMEOUT_EN
                    if (stall == STALL_LIM) begin
                        // Abort: sig and count freeze where they are
                        state     <= DONE;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        timeout_r <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b0;
                    end else if (accept) begin
                        stall <= '0;
                        sig   <= sig_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state    <= CHECK;
                            in_ready <= 1'b0;
                        end
                    end else begin
                        stall <= stall + 1'b1;
                    end
`else
                    if (accept) begin
                        sig   <= sig_next;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state    <= CHECK;
                            in_ready <= 1'b0;
                        end
                    end
`endif
                end
                CHECK: begin
                    state <= DONE;
                    pass  <= (sig == exp_sig);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intermout_sig_compactor.sv
// Directed bench for intermout_sig_compactor: a 2-sample instance for the
// hand-computed signature runs and a 16-sample instance for the long run,
// mid-run reset and stall behaviour.
module tb_intermout_sig_compactor;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Clock / reset
    always #5 clk = ~clk;

    // 2-sample instance
    logic       start2, valid2, ready2, busy2, done2, pass2, to2;
    logic [7:0] data2, exp2, sig2;
    logic [1:0] count2, st2;

    intermout_sig_compactor #(.WIDTH(8), .NSAMP(2), .POLY(8'h1D), .SEED(8'h00)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(valid2), .in_ready(ready2),
        .in_data(data2), .exp_sig(exp2), .sig(sig2), .count(count2), .busy(busy2),
        .done(done2), .pass(pass2), .timeout(to2), .state_dbg(st2)
    );

    // 16-sample instance
    logic       start16, valid16, ready16, busy16, done16, pass16, to16;
    logic [7:0] data16, exp16, sig16;
    logic [4:0] count16;
    logic [1:0] st16;

    intermout_sig_compactor #(.WIDTH(8), .NSAMP(16), .POLY(8'h1D), .SEED(8'h00), .TIMEOUT(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .in_valid(valid16), .in_ready(ready16),
        .in_data(data16), .exp_sig(exp16), .sig(sig16), .count(count16), .busy(busy16),
        .done(done16), .pass(pass16), .timeout(to16), .state_dbg(st16)
    );

    // Reference MISR step
    function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
    endfunction

    // Scoreboard check
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] d16 [16];
    logic [7:0] model;
    int         busy_cycles;
    int         waited;

    initial begin
        reset = 1'b1;
        start2 = 0; valid2 = 0; data2 = 0; exp2 = 0;
        start16 = 0; valid16 = 0; data16 = 0; exp16 = 0;

        // Reset state
        step(); step();
        check_eq("rst_sig", sig2, 8'h00);
        check_eq("rst_count", count2, 0);
        check_eq("rst_ready", ready2, 0);
        check_eq("rst_busy", busy2, 0);
        check_eq("rst_done", done2, 0);
        check_eq("rst_pass", pass2, 0);
        check_eq("rst_timeout", to2, 0);
        check_eq("rst_count16", count16, 0);
        reset = 1'b0;
        step();

        // Run 1: 0x80, 0x01 -> 0x80, 0x1C, matches exp 0x1C
        exp2 = 8'h1C;
        start2 = 1; step(); start2 = 0;
        check_eq("r1_ready", ready2, 1);
        check_eq("r1_busy", busy2, 1);
        valid2 = 1; data2 = 8'h80; step();
        check_eq("r1_sig0", sig2, 8'h80);
        check_eq("r1_cnt0", count2, 1);
        data2 = 8'h01; step();
        valid2 = 0;
        check_eq("r1_sig1", sig2, 8'h1C);
        check_eq("r1_chk_ready", ready2, 0);
        check_eq("r1_chk_done", done2, 0);
        step();
        check_eq("r1_done", done2, 1);
        check_eq("r1_pass", pass2, 1);
        check_eq("r1_busy_done", busy2, 0);
        check_eq("r1_count", count2, 2);

        // Run 2: same data, exp 0x1D -> fail
        exp2 = 8'h1D;
        start2 = 1; step(); start2 = 0;
        valid2 = 1; data2 = 8'h80; step();
        data2 = 8'h01; step();
        valid2 = 0; step();
        check_eq("r2_done", done2, 1);
        check_eq("r2_pass", pass2, 0);
        check_eq("r2_sig", sig2, 8'h1C);

        // Restart from DONE with a sample offered on the start edge
        start2 = 1; valid2 = 1; data2 = 8'h55; step();
        start2 = 0; valid2 = 0;
        check_eq("rs_count", count2, 0);
        check_eq("rs_sig", sig2, 8'h00);
        check_eq("rs_busy", busy2, 1);
        check_eq("rs_done", done2, 0);

        // No samples: stays busy for 100 cycles
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy2 === 1'b1) busy_cycles++;
        end
        check_eq("stall_busy100", busy_cycles, 100);
        check_eq("stall_count", count2, 0);

        // Mid-run reset on the 16-sample instance; start pulse in RUN ignored
        reset = 1; step(); reset = 0;
        start16 = 1; step(); start16 = 0;
        valid16 = 1;
        model = 8'h00;
        for (int i = 0; i < 5; i++) begin
            data16 = 8'(i * 19 + 3);
            model = misr_step(model, data16);
            if (i == 2) start16 = 1;
            step();
            start16 = 0;
        end
        valid16 = 0;
        check_eq("mr_count5", count16, 5);
        check_eq("mr_sig5", sig16, model);
        reset = 1; step(); reset = 0;
        check_eq("mr_rst_count", count16, 0);
        check_eq("mr_rst_sig", sig16, 8'h00);
        check_eq("mr_rst_busy", busy16, 0);
        check_eq("mr_rst_state", st16, 0);

        // Full 16-sample run, in_valid every other cycle
        model = 8'h00;
        for (int k = 0; k < 16; k++) begin
            d16[k] = 8'(k * 37 + 5);
            model = misr_step(model, d16[k]);
        end
        exp16 = model;
        start16 = 1; step(); start16 = 0;
        for (int k = 0; k < 16; k++) begin
            valid16 = 1; data16 = d16[k]; step();
            valid16 = 0;
            if (k < 15) step();
        end
        check_eq("l_chk_ready", ready16, 0);
        check_eq("l_chk_busy", busy16, 1);
        check_eq("l_chk_count", count16, 16);
        valid16 = 1; data16 = 8'hFF; step();
        check_eq("l_done", done16, 1);
        check_eq("l_pass", pass16, 1);
        step();
        valid16 = 0;
        check_eq("l_17th_count", count16, 16);
        check_eq("l_sig", sig16, model);

`ifdef SIGCMP_TIMEOUT_EN
        // Stall abort with TIMEOUT=4
        start16 = 1; step(); start16 = 0;
        waited = 0;
        while (done16 !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check_eq("to_cycles", waited, 5);
        check_eq("to_done", done16, 1);
        check_eq("to_timeout", to16, 1);
        check_eq("to_pass", pass16, 0);
        check_eq("to_count", count16, 0);
`else
        check_eq("to_tied", to16, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
